tdc_readout_ctrl: RTL and testbench

Single-clock sequencer for the TDC → FIFO → UART path.
- Acquisition mode: enables the TDC and writes each measurement into the FIFO, gated by almost_full.
- Drain mode: reads the FIFO word by word and emits each word as a 6-byte frame through the uart_tx byte handshake.
- Replaces the ad-hoc start/read logic at the top level; the FIFO read and write clocks are both clk.

---
 rtl/tdc_readout_ctrl_pkg.sv | 40 ++++
 rtl/tdc_readout_ctrl_frame_serializer.sv | 107 ++++++++++
 rtl/tdc_readout_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_readout_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tdc_readout_ctrl_pkg
// Shared constants, state encoding and the frame byte helper for the
// TDC -> FIFO -> UART readout sequencer.
//   SYNC_BYTE  : frame header byte
//   FRAME_LEN  : bytes per frame (header, 4 data bytes, checksum)
//   state_t    : 3-bit state encoding shared by the top and the serializer
//   frame_byte : returns byte idx of the frame built from a 32-bit word
// ----------------------------------------------------------------------------
package tdc_readout_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACQ      = 3'd1,
        ST_RD_CHECK = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_TX_BYTE  = 3'd4,
        ST_TX_WAIT  = 3'd5
    } state_t;

    // Byte idx of the frame: A5, word MSB..LSB, XOR of the four data bytes.
    function automatic logic [7:0] frame_byte(input logic [31:0] word,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            3'd5:    b = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tdc_readout_ctrl_frame_serializer.sv
// ----------------------------------------------------------------------------
// tdc_readout_ctrl_frame_serializer
// Sends one 6-byte frame for a 32-bit word over the uart_tx byte handshake.
// Owns the TX_BYTE/TX_WAIT states, the byte index and the per-byte timeout.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_start, i_word    : start strobe and word to frame
//   i_abort            : abandon the frame immediately
//   i_tx_active        : UART busy; no byte is offered while high
//   i_tx_done          : UART byte complete pulse
//   o_tx_dv, o_tx_byte : byte valid pulse and byte
//   o_frame_done       : pulse after the last byte's tx_done
//   o_frame_timeout    : pulse when a byte's tx_done never arrived
// ----------------------------------------------------------------------------
module tdc_readout_ctrl_frame_serializer
    import tdc_readout_ctrl_pkg::*;
#(
    parameter int TX_TIMEOUT = 1 << 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_word,
    input  logic        i_abort,
    input  logic        i_tx_active,
    input  logic        i_tx_done,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    output logic        o_frame_done,
    output logic        o_frame_timeout
);

    localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
    // The timeout pulse is raised one cycle early so that the parent's
    // registered error flag lands exactly TX_TIMEOUT cycles after tx_dv.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 2);

    state_t             r_state;
    logic [31:0]        r_word;
    logic [2:0]         r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_tx_dv;
    logic [7:0]         r_tx_byte;
    logic               r_frame_done;
    logic               r_frame_timeout;

    // Byte sequencing, handshake and timeout state machine.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_word          <= 32'h0000_0000;
            r_idx           <= 3'd0;
            r_tmo           <= '0;
            r_tx_dv         <= 1'b0;
            r_tx_byte       <= 8'h00;
            r_frame_done    <= 1'b0;
            r_frame_timeout <= 1'b0;
        end else begin
            r_tx_dv         <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_timeout <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_word  <= i_word;
                            r_idx   <= 3'd0;
                            r_state <= ST_TX_BYTE;
                        end
                    end
                    ST_TX_BYTE: begin
                        if (!i_tx_active) begin
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= frame_byte(r_word, r_idx);
                            r_tmo     <= '0;
                            r_state   <= ST_TX_WAIT;
                        end
                    end
                    ST_TX_WAIT: begin
                        if (i_tx_done) begin
                            if (r_idx == 3'(FRAME_LEN - 1)) begin
                                r_frame_done <= 1'b1;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_idx   <= r_idx + 3'd1;
                                r_state <= ST_TX_BYTE;
                            end
                        end else if (r_tmo == TMO_LAST) begin
                            r_frame_timeout <= 1'b1;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_tx_dv         = r_tx_dv;
    assign o_tx_byte       = r_tx_byte;
    assign o_frame_done    = r_frame_done;
    assign o_frame_timeout = r_frame_timeout;

endmodule

// File: rtl/tdc_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tdc_readout_ctrl
// Single-clock sequencer for the TDC -> FIFO -> UART path.
//   Acquisition: enables the TDC, writes each measurement (zero-extended) to
//   the FIFO unless almost_full, otherwise counts a drop (saturating).
//   Drain: pops the FIFO word by word and sends each as a 6-byte frame.
// Ports:
//   i_clk, i_rst_n                       : clock, async active-low reset
//   i_acq_start/i_acq_stop/i_read_start  : control pulses
//   i_abort                              : return to IDLE from any state
//   i_err_clr                            : clear sticky errors
//   i_tdc_done, i_tdc_data               : TDC measurement
//   i_fifo_*                             : FIFO status, read data, errors
//   i_tx_active, i_tx_done               : UART status
//   o_tdc_enable, o_fifo_wr_*, o_fifo_rd_en, o_tx_dv, o_tx_byte : strobes
//   o_busy, o_drain_done, o_drop_cnt, o_frame_cnt, o_err_*       : status
// ----------------------------------------------------------------------------
module tdc_readout_ctrl
    import tdc_readout_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int TX_TIMEOUT = 1 << 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_acq_start,
    input  logic              i_acq_stop,
    input  logic              i_read_start,
    input  logic              i_abort,
    input  logic              i_err_clr,
    input  logic              i_tdc_done,
    input  logic [DATA_W-1:0] i_tdc_data,
    input  logic              i_fifo_almost_full,
    input  logic              i_fifo_empty,
    input  logic [31:0]       i_fifo_rd_data,
    input  logic              i_fifo_wr_err,
    input  logic              i_fifo_rd_err,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_tdc_enable,
    output logic              o_fifo_wr_en,
    output logic [31:0]       o_fifo_wr_data,
    output logic              o_fifo_rd_en,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    output logic              o_busy,
    output logic              o_drain_done,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_frame_cnt,
    output logic              o_err_wr,
    output logic              o_err_rd,
    output logic              o_err_tx
);

    localparam int LAT_W = $clog2(RD_LAT + 2);

    state_t             r_state;
    logic               r_tdc_enable;
    logic               r_fifo_wr_en;
    logic [31:0]        r_fifo_wr_data;
    logic               r_fifo_rd_en;
    logic               r_busy;
    logic               r_drain_done;
    logic [15:0]        r_drop_cnt;
    logic [15:0]        r_frame_cnt;
    logic               r_err_wr;
    logic               r_err_rd;
    logic               r_err_tx;
    logic [LAT_W-1:0]   r_lat;
    logic [31:0]        r_word;
    logic               r_ser_start;

    logic               w_frame_done;
    logic               w_frame_timeout;

    // Top-level sequencer. While a frame is on the wire the top parks in
    // ST_TX_BYTE; the serializer walks its own TX_BYTE/TX_WAIT sub-states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_tdc_enable   <= 1'b0;
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= 32'h0000_0000;
            r_fifo_rd_en   <= 1'b0;
            r_busy         <= 1'b0;
            r_drain_done   <= 1'b0;
            r_drop_cnt     <= 16'h0000;
            r_frame_cnt    <= 16'h0000;
            r_lat          <= '0;
            r_word         <= 32'h0000_0000;
            r_ser_start    <= 1'b0;
        end else begin
            r_fifo_wr_en <= 1'b0;
            r_fifo_rd_en <= 1'b0;
            r_drain_done <= 1'b0;
            r_ser_start  <= 1'b0;
            if (i_abort) begin
                r_state      <= ST_IDLE;
                r_tdc_enable <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_acq_start) begin
                            r_state      <= ST_ACQ;
                            r_tdc_enable <= 1'b1;
                            r_busy       <= 1'b1;
                        end else if (i_read_start) begin
                            r_state <= ST_RD_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_ACQ: begin
                        // A measurement arriving with acq_stop is still stored.
                        if (i_tdc_done) begin
                            if (!i_fifo_almost_full) begin
                                r_fifo_wr_en   <= 1'b1;
                                r_fifo_wr_data <= 32'(i_tdc_data);
                            end else if (r_drop_cnt != 16'hFFFF) begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end
                        if (i_acq_stop) begin
                            r_state      <= ST_IDLE;
                            r_tdc_enable <= 1'b0;
                            r_busy       <= 1'b0;
                        end
                    end
                    ST_RD_CHECK: begin
                        if (i_fifo_empty) begin
                            r_drain_done <= 1'b1;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_fifo_rd_en <= 1'b1;
                            r_lat        <= '0;
                            r_state      <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (r_lat == LAT_W'(RD_LAT)) begin
                            r_word      <= i_fifo_rd_data;
                            r_ser_start <= 1'b1;
                            r_state     <= ST_TX_BYTE;
                        end else begin
                            r_lat <= r_lat + LAT_W'(1);
                        end
                    end
                    ST_TX_BYTE: begin
                        if (w_frame_done) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= ST_RD_CHECK;
                        end else if (w_frame_timeout) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_tdc_enable <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_wr <= 1'b0;
            r_err_rd <= 1'b0;
            r_err_tx <= 1'b0;
        end else begin
            if (i_fifo_wr_err)   r_err_wr <= 1'b1;
            else if (i_err_clr)  r_err_wr <= 1'b0;
            if (i_fifo_rd_err)   r_err_rd <= 1'b1;
            else if (i_err_clr)  r_err_rd <= 1'b0;
            if (w_frame_timeout && !i_abort) r_err_tx <= 1'b1;
            else if (i_err_clr)  r_err_tx <= 1'b0;
        end
    end

    tdc_readout_ctrl_frame_serializer #(
        .TX_TIMEOUT (TX_TIMEOUT)
    ) u_ser (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (r_ser_start),
        .i_word          (r_word),
        .i_abort         (i_abort),
        .i_tx_active     (i_tx_active),
        .i_tx_done       (i_tx_done),
        .o_tx_dv         (o_tx_dv),
        .o_tx_byte       (o_tx_byte),
        .o_frame_done    (w_frame_done),
        .o_frame_timeout (w_frame_timeout)
    );

    assign o_tdc_enable   = r_tdc_enable;
    assign o_fifo_wr_en   = r_fifo_wr_en;
    assign o_fifo_wr_data = r_fifo_wr_data;
    assign o_fifo_rd_en   = r_fifo_rd_en;
    assign o_busy         = r_busy;
    assign o_drain_done   = r_drain_done;
    assign o_drop_cnt     = r_drop_cnt;
    assign o_frame_cnt    = r_frame_cnt;
    assign o_err_wr       = r_err_wr;
    assign o_err_rd       = r_err_rd;
    assign o_err_tx       = r_err_tx;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tdc_readout_ctrl
// Directed bench for tdc_readout_ctrl with small FIFO and UART models.
// ----------------------------------------------------------------------------
module tb_tdc_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acq_start = 1'b0, acq_stop = 1'b0, read_start = 1'b0;
    logic        abort = 1'b0, err_clr = 1'b0;
    logic        tdc_done = 1'b0;
    logic [15:0] tdc_data = 16'h0000;
    logic        fifo_almost_full = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        fifo_wr_err = 1'b0, fifo_rd_err = 1'b0;
    logic        tx_active = 1'b0, tx_done = 1'b0;
    logic        tdc_enable, fifo_wr_en, fifo_rd_en, tx_dv, busy, drain_done;
    logic [31:0] fifo_wr_data;
    logic [7:0]  tx_byte;
    logic [15:0] drop_cnt, frame_cnt;
    logic        err_wr, err_rd, err_tx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdc_readout_ctrl #(.DATA_W(16), .RD_LAT(1), .TX_TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_acq_start(acq_start), .i_acq_stop(acq_stop), .i_read_start(read_start),
        .i_abort(abort), .i_err_clr(err_clr),
        .i_tdc_done(tdc_done), .i_tdc_data(tdc_data),
        .i_fifo_almost_full(fifo_almost_full), .i_fifo_empty(fifo_empty),
        .i_fifo_rd_data(fifo_rd_data), .i_fifo_wr_err(fifo_wr_err),
        .i_fifo_rd_err(fifo_rd_err), .i_tx_active(tx_active), .i_tx_done(tx_done),
        .o_tdc_enable(tdc_enable), .o_fifo_wr_en(fifo_wr_en),
        .o_fifo_wr_data(fifo_wr_data), .o_fifo_rd_en(fifo_rd_en),
        .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .o_busy(busy),
        .o_drain_done(drain_done), .o_drop_cnt(drop_cnt), .o_frame_cnt(frame_cnt),
        .o_err_wr(err_wr), .o_err_rd(err_rd), .o_err_tx(err_tx)
    );

    // FIFO model: read latency of one cycle, contents preloaded by the test.
    logic [31:0] fifo_mem [0:3];
    int          fifo_len = 0;
    int          fifo_rd_cnt = 0;
    assign fifo_empty = (fifo_rd_cnt >= fifo_len);

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[fifo_rd_cnt[1:0]];
            fifo_rd_cnt  <= fifo_rd_cnt + 1;
        end
    end

    // UART model: tx_done 10 cycles after tx_dv unless hung.
    logic uart_hang = 1'b0;
    int   uart_cnt = 0;
    always @(negedge clk) begin
        tx_done <= 1'b0;
        if (tx_dv && !uart_hang) begin
            uart_cnt  <= 10;
            tx_active <= 1'b1;
        end else if (uart_cnt == 1) begin
            uart_cnt  <= 0;
            tx_done   <= 1'b1;
            tx_active <= 1'b0;
        end else if (uart_cnt > 1) begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    // Monitor: byte log, strobe counters, handshake violations.
    logic [7:0] tx_log [0:31];
    int tx_log_n = 0, rd_pulses = 0, drain_pulses = 0, viol = 0;
    always @(negedge clk) begin
        if (tx_dv) begin
            if (tx_log_n < 32) tx_log[tx_log_n] <= tx_byte;
            tx_log_n <= tx_log_n + 1;
            if (tx_active) viol <= viol + 1;
        end
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
        if (drain_done) drain_pulses <= drain_pulses + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] data;
        logic        af;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic [15:0] exp_drop;
    } acq_vec_t;

    acq_vec_t vecs [4];

    initial begin
        int base, d0, k, n0;
        logic ok;
        logic [7:0] exp_bytes [0:5];

        vecs[0] = '{16'h1234, 1'b0, 1'b1, 32'h0000_1234, 16'd0};
        vecs[1] = '{16'hABCD, 1'b1, 1'b0, 32'h0000_0000, 16'd1};
        vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 32'h0000_FFFF, 16'd1};
        vecs[3] = '{16'h0000, 1'b1, 1'b0, 32'h0000_0000, 16'd2};
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'hDE; exp_bytes[2] = 8'hAD;
        exp_bytes[3] = 8'hBE; exp_bytes[4] = 8'hEF; exp_bytes[5] = 8'h22;
        fifo_mem[0] = 32'hDEAD_BEEF;
        fifo_mem[1] = 32'h0102_0304;
        fifo_mem[2] = 32'h1122_3344;
        fifo_mem[3] = 32'h0;
        fifo_len = 1;

        // Reset state
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, tdc_enable}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: reset mid-acquisition
        acq_start = 1'b1; tick(); acq_start = 1'b0;
        fifo_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin tdc_done = 1'b1; tick(); end
        tdc_done = 1'b0; fifo_almost_full = 1'b0; tick();
        chk("t1_drop_pre", {16'd0, drop_cnt}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_drop", {16'd0, drop_cnt}, 32'd0);
        chk("t1_async_en", {31'd0, tdc_enable}, 32'd0);
        chk("t1_async_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t1_post_busy", {31'd0, busy}, 32'd0);
        chk("t1_post_drop", {16'd0, drop_cnt}, 32'd0);

        // Test 6: acq_start beats read_start; read_start ignored in ACQ
        acq_start = 1'b1; read_start = 1'b1; tick();
        acq_start = 1'b0; read_start = 1'b0;
        chk("t6_en", {31'd0, tdc_enable}, 32'd1);
        read_start = 1'b1; tick(); read_start = 1'b0;
        tick(); tick(); tick();
        chk("t6_no_rd", rd_pulses, 32'd0);
        chk("t6_still_acq", {31'd0, tdc_enable}, 32'd1);

        // Test 2: table of acquisition vectors
        foreach (vecs[i]) begin
            tdc_data = vecs[i].data; fifo_almost_full = vecs[i].af; tdc_done = 1'b1;
            tick();
            tdc_done = 1'b0;
            chk($sformatf("t2_wr_en[%0d]", i), {31'd0, fifo_wr_en}, {31'd0, vecs[i].exp_wr});
            if (vecs[i].exp_wr)
                chk($sformatf("t2_wr_data[%0d]", i), fifo_wr_data, vecs[i].exp_wdata);
            chk($sformatf("t2_drop[%0d]", i), {16'd0, drop_cnt}, {16'd0, vecs[i].exp_drop});
            tick();
            chk($sformatf("t2_wr_1cyc[%0d]", i), {31'd0, fifo_wr_en}, 32'd0);
        end
        // tdc_done together with acq_stop is still written
        tdc_data = 16'h55AA; fifo_almost_full = 1'b0; tdc_done = 1'b1; acq_stop = 1'b1;
        tick();
        tdc_done = 1'b0; acq_stop = 1'b0;
        chk("t2_stop_wr", {31'd0, fifo_wr_en}, 32'd1);
        chk("t2_stop_wdata", fifo_wr_data, 32'h0000_55AA);
        chk("t2_stop_en", {31'd0, tdc_enable}, 32'd0);
        chk("t2_stop_busy", {31'd0, busy}, 32'd0);
        // Saturation
        acq_start = 1'b1; tick(); acq_start = 1'b0;
        fifo_almost_full = 1'b1; tdc_done = 1'b1;
        for (int i = 0; i < 65536; i++) tick();
        tdc_done = 1'b0; fifo_almost_full = 1'b0; tick();
        chk("t2_drop_sat", {16'd0, drop_cnt}, 32'h0000_FFFF);
        acq_stop = 1'b1; tick(); acq_stop = 1'b0;
        chk("t2_idle_en", {31'd0, tdc_enable}, 32'd0);

        // Sticky error flags: set wins over clear
        fifo_wr_err = 1'b1; fifo_rd_err = 1'b1; err_clr = 1'b1; tick();
        fifo_wr_err = 1'b0; fifo_rd_err = 1'b0; err_clr = 1'b0;
        chk("err_wr_set", {31'd0, err_wr}, 32'd1);
        chk("err_rd_set", {31'd0, err_rd}, 32'd1);
        tick();
        chk("err_wr_sticky", {31'd0, err_wr}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_wr_clr", {31'd0, err_wr}, 32'd0);
        chk("err_rd_clr", {31'd0, err_rd}, 32'd0);

        // Test 3: drain one word as a frame
        base = tx_log_n; d0 = drain_pulses;
        read_start = 1'b1; tick(); read_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (drain_pulses > d0) ok = 1'b1;
        end
        chk("t3_drain_seen", {31'd0, ok}, 32'd1);
        chk("t3_nbytes", tx_log_n - base, 32'd6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("t3_byte[%0d]", j), {24'd0, tx_log[base + j]}, {24'd0, exp_bytes[j]});
        chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_drain_once", drain_pulses - d0, 32'd1);
        chk("t3_viol", viol, 32'd0);

        // Test 4: UART timeout
        fifo_len = 2; uart_hang = 1'b1;
        read_start = 1'b1; tick(); read_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (tx_dv) ok = 1'b1;
        end
        chk("t4_dv_seen", {31'd0, ok}, 32'd1);
        k = 0;
        while (!err_tx && k < 200) begin tick(); k++; end
        chk("t4_tmo_cycles", k, 32'd64);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        tick();
        chk("t4_err_sticky", {31'd0, err_tx}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_err_clr", {31'd0, err_tx}, 32'd0);
        uart_hang = 1'b0;

        // Test 5: abort in TX_WAIT of byte 2
        fifo_len = 3; base = tx_log_n;
        read_start = 1'b1; tick(); read_start = 1'b0;
        n0 = 0;
        for (int i = 0; i < 200 && n0 < 3; i++) begin
            tick();
            if (tx_dv) n0++;
        end
        chk("t5_three_dv", n0, 32'd3);
        tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        n0 = tx_log_n;
        for (int i = 0; i < 40; i++) tick();
        chk("t5_no_more_dv", tx_log_n - n0, 32'd0);
        chk("t5_byte2", {24'd0, tx_log[base + 2]}, 32'h0000_0022);
        d0 = drain_pulses;
        read_start = 1'b1; tick(); read_start = 1'b0;
        tick(); tick();
        chk("t5_drain", drain_pulses - d0, 32'd1);
        chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
